bsg_packet_len_check: RTL and testbench

Packet length checker. It sits directly upstream of the store-and-forward buffer and generates that buffer's per-packet `error_i`. Each packet's first beat is a header that declares the packet's total length in beats. The block counts beats and, on the last beat, flags any mismatch or out-of-range declaration. Data passes through one registered pipeline stage at full throughput.

---
 rtl/bsg_packet_len_pkg.sv | 15 +
 rtl/bsg_dff_reset_en.sv | 34 +++
 rtl/bsg_packet_len_counter.sv | 37 +++
 rtl/bsg_packet_len_check.sv | 156 +++++++++++++++
 tb/tb_bsg_packet_len_check.sv | 247 ++++++++++++++++++++++++
 5 files changed

// File: rtl/bsg_packet_len_pkg.sv
// rtl/bsg_packet_len_pkg.sv - shared types and helpers for the packet length checker
package bsg_packet_len_pkg;

    // Packet framing state: waiting for a header beat, or inside a packet body
    typedef enum logic {
        e_header = 1'b0,
        e_body   = 1'b1
    } len_state_e;

    // Beat counter must hold max_beats+1 so an overlong packet saturates one past legal
    function automatic int beat_count_width_f(input int max_beats);
        return $clog2(max_beats + 2);
    endfunction

endpackage

// File: rtl/bsg_dff_reset_en.sv
// rtl/bsg_dff_reset_en.sv - enabled register with synchronous active-high clear
module bsg_dff_reset_en #(
    parameter int width_p = 1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               en_i,
    input  logic [width_p-1:0] data_i,
    output logic [width_p-1:0] data_o
);

    logic [width_p-1:0] data_q;
    logic [width_p-1:0] data_d;

    // Hold unless enabled
    always_comb begin
        data_d = data_q;
        if (en_i) begin
            data_d = data_i;
        end
    end

    // State register with synchronous clear
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            data_q <= '0;
        end else begin
            data_q <= data_d;
        end
    end

    assign data_o = data_q;

endmodule

// File: rtl/bsg_packet_len_counter.sv
// rtl/bsg_packet_len_counter.sv - saturating up-counter with load-to-1 and enable
module bsg_packet_len_counter #(
    parameter int                 width_p = 4,
    parameter logic [width_p-1:0] max_p   = '1
) (
    input  logic               clk_i,
    input  logic               reset_i,
    input  logic               load_i,
    input  logic               en_i,
    output logic [width_p-1:0] count_o
);

    logic [width_p-1:0] count_q;
    logic [width_p-1:0] count_d;

    // Load wins over increment; increment stops at max_p and never wraps
    always_comb begin
        count_d = count_q;
        if (load_i) begin
            count_d = width_p'(1);
        end else if (en_i && (count_q != max_p)) begin
            count_d = count_q + width_p'(1);
        end
    end

    // Count register with synchronous clear
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign count_o = count_q;

endmodule

// File: rtl/bsg_packet_len_check.sv
// rtl/bsg_packet_len_check.sv - per-packet declared-length checker with one-stage output register
module bsg_packet_len_check
    import bsg_packet_len_pkg::*;
#(
    parameter int width_p       = 16,
    parameter int len_width_p   = 8,
    parameter int max_beats_p   = 8,
    parameter int count_width_p = 16
) (
    input  logic                     clk_i,
    input  logic                     reset_i,
    input  logic [width_p-1:0]       data_i,
    input  logic                     v_i,
    input  logic                     last_i,
    output logic                     ready_o,
    output logic [width_p-1:0]       data_o,
    output logic                     v_o,
    output logic                     last_o,
    output logic                     error_o,
    input  logic                     ready_i,
    output logic [count_width_p-1:0] good_count_o,
    output logic [count_width_p-1:0] bad_count_o
);

    localparam int cnt_w_lp = beat_count_width_f(max_beats_p);
    localparam int cmp_w_lp = (len_width_p > cnt_w_lp) ? len_width_p : cnt_w_lp;
    localparam logic [cnt_w_lp-1:0] cnt_max_lp = cnt_w_lp'(max_beats_p + 1);

    len_state_e             state_q, state_d;
    logic [len_width_p-1:0] declared_len_q, declared_len_d;

    logic                   accept;
    logic                   beat_load;
    logic                   beat_en;
    logic [cnt_w_lp-1:0]    beat_count;
    logic [cnt_w_lp-1:0]    count_post;
    logic [len_width_p-1:0] cur_len;
    logic                   len_error;
    logic                   v_q;
    logic                   last_q;
    logic                   err_q;

    assign ready_o = ~v_o | ready_i;
    assign accept  = v_i & ready_o;

    // Framing FSM; also selects which length/count pair the error rule sees this beat
    always_comb begin
        state_d        = state_q;
        declared_len_d = declared_len_q;
        beat_load      = 1'b0;
        beat_en        = 1'b0;
        cur_len        = declared_len_q;
        count_post     = (beat_count == cnt_max_lp) ? beat_count : beat_count + cnt_w_lp'(1);
        case (state_q)
            e_header: begin
                cur_len    = data_i[len_width_p-1:0];
                count_post = cnt_w_lp'(1);
                if (accept) begin
                    declared_len_d = data_i[len_width_p-1:0];
                    beat_load      = 1'b1;
                    if (!last_i) begin
                        state_d = e_body;
                    end
                end
            end
            e_body: begin
                if (accept) begin
                    beat_en = 1'b1;
                    if (last_i) begin
                        state_d = e_header;
                    end
                end
            end
            default: state_d = e_header;
        endcase
    end

    // Zero length, over-max length, and count disagreement are all errors
    always_comb begin
        len_error = (cur_len == '0)
                  | (cmp_w_lp'(cur_len) > cmp_w_lp'(max_beats_p))
                  | (cmp_w_lp'(cur_len) != cmp_w_lp'(count_post));
    end

    // FSM and latched header length
    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q        <= e_header;
            declared_len_q <= '0;
        end else begin
            state_q        <= state_d;
            declared_len_q <= declared_len_d;
        end
    end

    bsg_packet_len_counter #(
        .width_p (cnt_w_lp),
        .max_p   (cnt_max_lp)
    ) beat_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (beat_load),
        .en_i    (beat_en),
        .count_o (beat_count)
    );

    // Statistics advance at input acceptance of the last beat
    bsg_packet_len_counter #(
        .width_p (count_width_p),
        .max_p   ({count_width_p{1'b1}})
    ) good_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (1'b0),
        .en_i    (accept & last_i & ~len_error),
        .count_o (good_count_o)
    );

    bsg_packet_len_counter #(
        .width_p (count_width_p),
        .max_p   ({count_width_p{1'b1}})
    ) bad_counter (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .load_i  (1'b0),
        .en_i    (accept & last_i & len_error),
        .count_o (bad_count_o)
    );

    // Valid bit reloads whenever the slot is free or being drained
    bsg_dff_reset_en #(
        .width_p (1)
    ) valid_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (ready_o),
        .data_i  (v_i),
        .data_o  (v_q)
    );

    // Payload only loads on an accepted beat so it holds steady under backpressure
    bsg_dff_reset_en #(
        .width_p (width_p + 2)
    ) payload_reg (
        .clk_i   (clk_i),
        .reset_i (reset_i),
        .en_i    (accept),
        .data_i  ({data_i, last_i, last_i & len_error}),
        .data_o  ({data_o, last_q, err_q})
    );

    assign v_o     = v_q;
    assign last_o  = last_q & v_q;
    assign error_o = err_q & v_q;

endmodule

// File: tb/tb_bsg_packet_len_check.sv
// tb/tb_bsg_packet_len_check.sv - scoreboard bench for bsg_packet_len_check
module tb_bsg_packet_len_check;

    logic        clk = 1'b0;
    logic        reset_i = 1'b1;
    logic [15:0] data_i = '0;
    logic        v_i = 1'b0;
    logic        last_i = 1'b0;
    logic        ready_o;
    logic [15:0] data_o;
    logic        v_o;
    logic        last_o;
    logic        error_o;
    logic        ready_i = 1'b1;
    logic [15:0] good_count_o;
    logic [15:0] bad_count_o;

    bsg_packet_len_check #(
        .width_p       (16),
        .len_width_p   (8),
        .max_beats_p   (8),
        .count_width_p (16)
    ) dut (
        .clk_i        (clk),
        .reset_i      (reset_i),
        .data_i       (data_i),
        .v_i          (v_i),
        .last_i       (last_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .v_o          (v_o),
        .last_o       (last_o),
        .error_o      (error_o),
        .ready_i      (ready_i),
        .good_count_o (good_count_o),
        .bad_count_o  (bad_count_o)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [15:0] d;
        logic        l;
        logic        e;
        int          acc;
        bit          lat;
    } exp_t;

    exp_t        sb[$];
    int          cyc = 0;
    int          errors = 0;
    int          checks = 0;
    int          stall_lo = -1;
    int          stall_hi = -2;
    bit          lat_chk = 1'b1;
    int          first_acc = 0;
    int          last_acc = 0;
    bit          hold_v = 1'b0;
    logic [17:0] hold_val = '0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic step(input logic v, input logic [15:0] d, input logic l, output bit acc);
        @(negedge clk);
        ready_i = !((cyc >= stall_lo) && (cyc <= stall_hi));
        v_i     = v;
        data_i  = d;
        last_i  = l;
        #1;
        acc = v_i && ready_o;
    endtask

    task automatic idle(input int n);
        bit acc;
        repeat (n) step(1'b0, 16'h0, 1'b0, acc);
    endtask

    task automatic send(input logic [15:0] d, input logic l, input logic e);
        bit   acc;
        int   n;
        exp_t x;
        acc = 1'b0;
        n   = 0;
        while (!acc && n < 50) begin
            step(1'b1, d, l, acc);
            n++;
        end
        if (!acc) begin
            check("accept_timeout", 32'(0), 32'(1));
        end else begin
            x.d = d; x.l = l; x.e = e; x.acc = cyc; x.lat = lat_chk;
            sb.push_back(x);
            last_acc = cyc;
        end
    endtask

    task automatic drain();
        int n;
        n = 0;
        while (sb.size() > 0 && n < 100) begin
            idle(1);
            n++;
        end
        if (sb.size() > 0) check("drain_timeout", 32'(sb.size()), 32'(0));
    endtask

    task automatic do_reset(input bit drain_first);
        if (drain_first) drain();
        @(negedge clk);
        reset_i = 1'b1;
        v_i     = 1'b0;
        last_i  = 1'b0;
        ready_i = 1'b1;
        @(negedge clk);
        reset_i = 1'b0;
        #1;
        check("reset_v_o", 32'(v_o), 32'(0));
        check("reset_last_o", 32'(last_o), 32'(0));
        check("reset_error_o", 32'(error_o), 32'(0));
        check("reset_ready_o", 32'(ready_o), 32'(1));
        check("reset_good", 32'(good_count_o), 32'(0));
        check("reset_bad", 32'(bad_count_o), 32'(0));
    endtask

    // Monitor: consumes output beats against the scoreboard, watches stall behaviour
    always @(negedge clk) begin
        exp_t x;
        #2;
        if (v_o && ready_i) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_beat: got data %0h with no beat expected", data_o);
            end else begin
                x = sb.pop_front();
                check("beat_data", 32'(data_o), 32'(x.d));
                check("beat_last", 32'(last_o), 32'(x.l));
                check("beat_error", 32'(error_o), 32'(x.e));
                if (x.lat) check("beat_latency", 32'(cyc - x.acc), 32'(1));
            end
        end
        if (v_o && !ready_i) begin
            check("stall_ready_o", 32'(ready_o), 32'(0));
            if (hold_v) check("stall_hold", 32'({data_o, last_o, error_o}), 32'(hold_val));
            hold_v   = 1'b1;
            hold_val = {data_o, last_o, error_o};
        end else begin
            hold_v = 1'b0;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int s0;
        do_reset(1'b0);
        check("reset_data_o", 32'(data_o), 32'(0));

        // 1: correct 3-beat packet
        send(16'h0003, 1'b0, 1'b0);
        send(16'h1111, 1'b0, 1'b0);
        send(16'h2222, 1'b1, 1'b0);
        drain();
        check("t1_good", 32'(good_count_o), 32'(1));
        check("t1_bad", 32'(bad_count_o), 32'(0));

        // 2: short packet, then a correct 4-beat packet
        do_reset(1'b1);
        send(16'h0003, 1'b0, 1'b0);
        send(16'h2001, 1'b1, 1'b1);
        send(16'h0004, 1'b0, 1'b0);
        send(16'h2101, 1'b0, 1'b0);
        send(16'h2102, 1'b0, 1'b0);
        send(16'h2103, 1'b1, 1'b0);
        drain();
        check("t2_good", 32'(good_count_o), 32'(1));
        check("t2_bad", 32'(bad_count_o), 32'(1));

        // 3: single-beat packets, zero length and length one
        do_reset(1'b1);
        send(16'h0000, 1'b1, 1'b1);
        send(16'h0001, 1'b1, 1'b0);
        drain();
        check("t3_good", 32'(good_count_o), 32'(1));
        check("t3_bad", 32'(bad_count_o), 32'(1));

        // 4: over-max declaration, then overlong packet past saturation
        do_reset(1'b1);
        send(16'h0009, 1'b0, 1'b0);
        for (int i = 1; i < 8; i++) send(16'h4000 + 16'(i), 1'b0, 1'b0);
        send(16'h40FF, 1'b1, 1'b1);
        send(16'h0003, 1'b0, 1'b0);
        for (int i = 1; i < 11; i++) send(16'h4100 + 16'(i), 1'b0, 1'b0);
        send(16'h41FF, 1'b1, 1'b1);
        drain();
        check("t4_good", 32'(good_count_o), 32'(0));
        check("t4_bad", 32'(bad_count_o), 32'(2));

        // 5: streaming 4-beat packets with a 3-cycle downstream stall
        do_reset(1'b1);
        lat_chk  = 1'b0;
        s0       = cyc;
        stall_lo = s0 + 3;
        stall_hi = s0 + 5;
        for (int p = 0; p < 3; p++) begin
            send(16'h0004, 1'b0, 1'b0);
            if (p == 0) first_acc = last_acc;
            send(16'h5001 + 16'(p * 16), 1'b0, 1'b0);
            send(16'h5002 + 16'(p * 16), 1'b0, 1'b0);
            send(16'h5003 + 16'(p * 16), 1'b1, 1'b0);
        end
        check("t5_throughput", 32'(last_acc - first_acc), 32'(14));
        drain();
        stall_lo = -1;
        stall_hi = -2;
        lat_chk  = 1'b1;
        check("t5_good", 32'(good_count_o), 32'(3));
        check("t5_bad", 32'(bad_count_o), 32'(0));

        // 6: reset mid-packet, next beat is a header
        do_reset(1'b1);
        send(16'h0005, 1'b0, 1'b0);
        send(16'h6001, 1'b0, 1'b0);
        do_reset(1'b0);
        send(16'h0001, 1'b1, 1'b0);
        drain();
        check("t6_good", 32'(good_count_o), 32'(1));
        check("t6_bad", 32'(bad_count_o), 32'(0));

        idle(2);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
